// File: rtl/video_timing_pkg.sv
// Shared raster constants for the 720p60 HDMI path and the TMDS control tokens
// used by the channel encoders, so timing and encoding agree on one source.
package video_timing_pkg;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned FC_W     = 6;

  localparam int unsigned ACTIVE_H_720      = 1280;
  localparam int unsigned H_FRONT_PORCH_720 = 110;
  localparam int unsigned H_SYNC_WIDTH_720  = 40;
  localparam int unsigned H_BACK_PORCH_720  = 220;
  localparam int unsigned H_TOTAL_720 =
    ACTIVE_H_720 + H_FRONT_PORCH_720 + H_SYNC_WIDTH_720 + H_BACK_PORCH_720;

  localparam int unsigned ACTIVE_LINES_720  = 720;
  localparam int unsigned V_FRONT_PORCH_720 = 5;
  localparam int unsigned V_SYNC_WIDTH_720  = 5;
  localparam int unsigned V_BACK_PORCH_720  = 20;
  localparam int unsigned V_TOTAL_720 =
    ACTIVE_LINES_720 + V_FRONT_PORCH_720 + V_SYNC_WIDTH_720 + V_BACK_PORCH_720;

  localparam int unsigned FPS_720 = 60;

  // Control-period tokens, indexed by {c1, c0} = {vs, hs} on the blue channel.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic logic [9:0] tmds_ctrl_token(input logic [1:0] ctrl);
    case (ctrl)
      2'b00:   return TMDS_CTRL_00;
      2'b01:   return TMDS_CTRL_01;
      2'b10:   return TMDS_CTRL_10;
      default: return TMDS_CTRL_11;
    endcase
  endfunction

endpackage

// File: rtl/video_sig_gen.sv
// Free-running raster timing generator: cascaded column/line wrap counters with
// sync, active-draw, new-frame and frame-count decode registered alongside them.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_H      = ACTIVE_H_720,
  parameter int unsigned H_FRONT_PORCH = H_FRONT_PORCH_720,
  parameter int unsigned H_SYNC_WIDTH  = H_SYNC_WIDTH_720,
  parameter int unsigned H_BACK_PORCH  = H_BACK_PORCH_720,
  parameter int unsigned ACTIVE_LINES  = ACTIVE_LINES_720,
  parameter int unsigned V_FRONT_PORCH = V_FRONT_PORCH_720,
  parameter int unsigned V_SYNC_WIDTH  = V_SYNC_WIDTH_720,
  parameter int unsigned V_BACK_PORCH  = V_BACK_PORCH_720,
  parameter int unsigned FPS           = FPS_720
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nf_out,
  output logic [FC_W-1:0]     fc_out
);

  localparam int unsigned H_TOTAL = ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int unsigned V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(H_TOTAL - 1);
  localparam logic [HCOUNT_W-1:0] H_ACT    = HCOUNT_W'(ACTIVE_H);
  localparam logic [HCOUNT_W-1:0] HS_START = HCOUNT_W'(ACTIVE_H + H_FRONT_PORCH);
  localparam logic [HCOUNT_W-1:0] HS_END   = HCOUNT_W'(ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH);

  localparam logic [VCOUNT_W-1:0] V_LAST   = VCOUNT_W'(V_TOTAL - 1);
  localparam logic [VCOUNT_W-1:0] V_ACT    = VCOUNT_W'(ACTIVE_LINES);
  localparam logic [VCOUNT_W-1:0] VS_START = VCOUNT_W'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [VCOUNT_W-1:0] VS_END   = VCOUNT_W'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);

  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FPS - 1);

  logic [HCOUNT_W-1:0] hcount_nxt;
  logic [VCOUNT_W-1:0] vcount_nxt;
  logic                hs_nxt, vs_nxt, ad_nxt, nf_nxt;
  logic [FC_W-1:0]     fc_nxt;

  always_comb begin
    hcount_nxt = hcount_out + HCOUNT_W'(1);
    vcount_nxt = vcount_out;
    if (hcount_out == H_LAST) begin
      hcount_nxt = '0;
      vcount_nxt = (vcount_out == V_LAST) ? '0 : vcount_out + VCOUNT_W'(1);
    end
  end

  // Decode the upcoming position so every registered output matches the counters.
  always_comb begin
    hs_nxt = (hcount_nxt >= HS_START) && (hcount_nxt < HS_END);
    vs_nxt = (vcount_nxt >= VS_START) && (vcount_nxt < VS_END);
    ad_nxt = (hcount_nxt < H_ACT) && (vcount_nxt < V_ACT);
    nf_nxt = (hcount_nxt == H_ACT) && (vcount_nxt == V_ACT);
    fc_nxt = fc_out;
    if (nf_nxt) begin
      fc_nxt = (fc_out == FC_LAST) ? '0 : fc_out + FC_W'(1);
    end
  end

  // Reset tuple is the decode of the last blanking pixel, so release lands on (0,0).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_out <= H_LAST;
      vcount_out <= V_LAST;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      ad_out     <= 1'b0;
      nf_out     <= 1'b0;
      fc_out     <= '0;
    end else begin
      hcount_out <= hcount_nxt;
      vcount_out <= vcount_nxt;
      hs_out     <= hs_nxt;
      vs_out     <= vs_nxt;
      ad_out     <= ad_nxt;
      nf_out     <= nf_nxt;
      fc_out     <= fc_nxt;
    end
  end

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen on a reduced raster; expected outputs come from the
// pixel index since reset release, decoded with plain arithmetic.
`timescale 1ns/1ps
module tb_video_sig_gen;

  localparam int AH = 16, HFP = 3, HSW = 4, HBP = 5;
  localparam int AL = 10, VFP = 2, VSW = 2, VBP = 3;
  localparam int FPS = 60;
  localparam int HT = AH + HFP + HSW + HBP;
  localparam int VT = AL + VFP + VSW + VBP;
  localparam longint FRAME = HT * VT;
  localparam longint NF_IDX = AL * HT + AH;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;
  } tuple_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hs_out, vs_out, ad_out, nf_out;
  logic [5:0]  fc_out;
  tuple_t      act;

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;

  video_sig_gen #(
    .ACTIVE_H(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
    .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
    .FPS(FPS)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hs_out(hs_out), .vs_out(vs_out), .ad_out(ad_out), .nf_out(nf_out),
    .fc_out(fc_out)
  );

  assign act = {hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out};

  always #5 clk_in = ~clk_in;

  // n = rising edges since reset release; n = 0 is the reset tuple.
  function automatic tuple_t model(longint n);
    tuple_t t;
    longint k, frames;
    t = '0;
    if (n == 0) begin
      t.h = 11'(HT - 1);
      t.v = 10'(VT - 1);
      return t;
    end
    k      = (n - 1) % FRAME;
    t.h    = 11'(k % HT);
    t.v    = 10'(k / HT);
    t.hs   = (t.h >= AH + HFP) && (t.h < AH + HFP + HSW);
    t.vs   = (t.v >= AL + VFP) && (t.v < AL + VFP + VSW);
    t.ad   = (t.h < AH) && (t.v < AL);
    t.nf   = (t.h == AH) && (t.v == AL);
    frames = (n - 1 >= NF_IDX) ? ((n - 1 - NF_IDX) / FRAME + 1) : 0;
    t.fc   = 6'(frames % FPS);
    return t;
  endfunction

  function automatic string fmt(tuple_t t);
    return $sformatf("(%0d,%0d) hs=%0b vs=%0b ad=%0b nf=%0b fc=%0d",
                     t.h, t.v, t.hs, t.vs, t.ad, t.nf, t.fc);
  endfunction

  task automatic advance();
    @(posedge clk_in);
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic do_reset(int hold);
    rst_n_in = 1'b0;
    repeat (hold) @(negedge clk_in);
    #($urandom_range(1, 3));
    rst_n_in = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    #2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      vectors++;
      if (act !== model(0)) begin
        miscompares++;
        $display("FAIL reset_hold: got %s want %s", fmt(act), fmt(model(0)));
      end
    end
    #($urandom_range(1, 3));
    rst_n_in = 1'b1;
    cyc = 0;
    advance();
    vectors++;
    if (act !== model(1)) begin
      miscompares++;
      $display("FAIL first_edge: got %s want %s", fmt(act), fmt(model(1)));
    end
    vectors++;
    if (hcount_out !== 11'd0 || vcount_out !== 10'd0 || ad_out !== 1'b1) begin
      miscompares++;
      $display("FAIL first_pixel: got (%0d,%0d) ad=%0b want (0,0) ad=1",
               hcount_out, vcount_out, ad_out);
    end
  endtask

  task automatic test_line();
    int ad_n = 0, hs_n = 0, hs_first = -1;
    tuple_t prev;
    prev = '0;
    for (int i = 0; i < HT; i++) begin
      vectors++;
      if (act !== model(cyc)) begin
        miscompares++;
        $display("FAIL line_decode: got %s want %s", fmt(act), fmt(model(cyc)));
      end
      if (ad_out) ad_n++;
      if (hs_out) begin
        if (hs_first < 0) hs_first = int'(hcount_out);
        hs_n++;
      end
      prev = act;
      advance();
    end
    vectors++;
    if (ad_n != AH) begin
      miscompares++;
      $display("FAIL line_ad_count: got %0d want %0d", ad_n, AH);
    end
    vectors++;
    if (hs_n != HSW || hs_first != AH + HFP) begin
      miscompares++;
      $display("FAIL line_hs: got count %0d start %0d want count %0d start %0d",
               hs_n, hs_first, HSW, AH + HFP);
    end
    vectors++;
    if (prev.h !== 11'(HT - 1) || prev.v !== 10'd0 || hcount_out !== 11'd0 || vcount_out !== 10'd1) begin
      miscompares++;
      $display("FAIL line_wrap: got (%0d,%0d)->(%0d,%0d) want (%0d,0)->(0,1)",
               prev.h, prev.v, hcount_out, vcount_out, HT - 1);
    end
  endtask

  task automatic test_frame();
    longint nf_at[$];
    longint vs_n = 0;
    tuple_t prev;
    prev = act;
    for (longint i = 0; i < 2 * FRAME + HT; i++) begin
      vectors++;
      if (act !== model(cyc)) begin
        miscompares++;
        $display("FAIL frame_decode @%0d: got %s want %s", cyc, fmt(act), fmt(model(cyc)));
      end
      if (nf_out) nf_at.push_back(cyc);
      if (i < FRAME && vs_out) vs_n++;
      if (i > 0 && prev.h == 11'(HT - 1) && prev.v == 10'(VT - 1)) begin
        vectors++;
        if (hcount_out !== 11'd0 || vcount_out !== 10'd0) begin
          miscompares++;
          $display("FAIL frame_wrap: got (%0d,%0d) want (0,0)", hcount_out, vcount_out);
        end
      end
      prev = act;
      advance();
    end
    vectors++;
    if (nf_at.size() < 2 || (nf_at[1] - nf_at[0]) != FRAME) begin
      miscompares++;
      $display("FAIL frame_period: got %0d pulses gap %0d want gap %0d", nf_at.size(),
               (nf_at.size() >= 2) ? nf_at[1] - nf_at[0] : 0, FRAME);
    end
    vectors++;
    if (vs_n != VSW * HT) begin
      miscompares++;
      $display("FAIL frame_vs_count: got %0d want %0d", vs_n, VSW * HT);
    end
  endtask

  task automatic test_frame_count();
    int pulses = 0;
    do_reset(int'($urandom_range(1, 4)));
    for (longint i = 0; i < 61 * FRAME + NF_IDX + 10; i++) begin
      advance();
      vectors++;
      if (act !== model(cyc)) begin
        miscompares++;
        $display("FAIL fc_decode @%0d: got %s want %s", cyc, fmt(act), fmt(model(cyc)));
      end
      if (nf_out) begin
        pulses++;
        vectors++;
        if (fc_out !== 6'(pulses % FPS)) begin
          miscompares++;
          $display("FAIL fc_step: pulse %0d got fc=%0d want %0d", pulses, fc_out, pulses % FPS);
        end
        if (pulses == 61) break;
      end
    end
    vectors++;
    if (pulses != 61 || fc_out !== 6'd1) begin
      miscompares++;
      $display("FAIL fc_61: got %0d pulses fc=%0d want 61 pulses fc=1", pulses, fc_out);
    end
  endtask

  task automatic test_mid_reset();
    for (int r = 0; r < 3; r++) begin
      int th, tv;
      bit found = 0;
      th = (r == 0) ? AH / 2 : int'($urandom_range(0, HT - 1));
      tv = (r == 0) ? AL / 2 : int'($urandom_range(0, VT - 1));
      for (longint i = 0; i < FRAME + 2; i++) begin
        vectors++;
        if (act !== model(cyc)) begin
          miscompares++;
          $display("FAIL midrst_run: got %s want %s", fmt(act), fmt(model(cyc)));
        end
        if (hcount_out == 11'(th) && vcount_out == 10'(tv)) begin
          found = 1;
          break;
        end
        advance();
      end
      vectors++;
      if (!found) begin
        miscompares++;
        $display("FAIL midrst_target: got no visit want (%0d,%0d)", th, tv);
      end
      #2;
      rst_n_in = 1'b0;
      #1;
      vectors++;
      if (act !== model(0)) begin
        miscompares++;
        $display("FAIL midrst_async: got %s want %s", fmt(act), fmt(model(0)));
      end
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk_in);
        vectors++;
        if (act !== model(0)) begin
          miscompares++;
          $display("FAIL midrst_hold: got %s want %s", fmt(act), fmt(model(0)));
        end
      end
      #($urandom_range(1, 3));
      rst_n_in = 1'b1;
      cyc = 0;
      advance();
      vectors++;
      if (act !== model(1)) begin
        miscompares++;
        $display("FAIL midrst_restart: got %s want %s", fmt(act), fmt(model(1)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_frame_count();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/video_sig_gen.md
Name: video_sig_gen

Overview:
- Raster timing generator for the HDMI output path, default 1280x720 at 60 Hz with a 74.25 MHz pixel clock.
- Produces pixel coordinates, active-draw, hsync, vsync, a new-frame strobe and a frame counter.
- Sits directly upstream of the three TMDS encoders:
  - ad_out drives their video-enable input.
  - {vs_out, hs_out} drives the blue channel's control input.
- Pixel pipelines key off hcount_out/vcount_out.

Parameters:
- ACTIVE_H, 1280, visible pixels per line
- H_FRONT_PORCH, 110, blank pixels between active and hsync
- H_SYNC_WIDTH, 40, hsync pulse width in pixels
- H_BACK_PORCH, 220, blank pixels after hsync
- ACTIVE_LINES, 720, visible lines per frame
- V_FRONT_PORCH, 5, blank lines between active and vsync
- V_SYNC_WIDTH, 5, vsync pulse width in lines
- V_BACK_PORCH, 20, blank lines after vsync
- FPS, 60, frame counter modulus

Derived values:
- H_TOTAL = sum of the four horizontal values (1650).
- V_TOTAL = sum of the four vertical values (750).

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous active-low reset
- hcount_out  output  11  current pixel column, 0..H_TOTAL-1
- vcount_out  output  10  current line, 0..V_TOTAL-1
- hs_out  output  1  horizontal sync, active high
- vs_out  output  1  vertical sync, active high
- ad_out  output  1  active draw; high when hcount<ACTIVE_H and vcount<ACTIVE_LINES
- nf_out  output  1  new-frame strobe, one cycle
- fc_out  output  6  frame count, 0..FPS-1

Behaviour:
- One clock, clk_in. Reset is asynchronous and active-low on rst_n_in; every register clears immediately on its assertion.
- All outputs are registered. On every cycle they form a coherent tuple describing the position (hcount_out, vcount_out).
- Reset values:
  - hcount_out = H_TOTAL-1 (1649)
  - vcount_out = V_TOTAL-1 (749)
  - hs_out = 0, vs_out = 0, ad_out = 0, nf_out = 0, fc_out = 0
  - This tuple is the legitimate decode of the last blanking pixel, so nothing is special-cased.
- Advance, every rising edge with reset released:
  - If hcount = H_TOTAL-1: hcount <- 0, and vcount <- (vcount = V_TOTAL-1) ? 0 : vcount+1.
  - Else: hcount <- hcount+1, vcount unchanged.
  - First edge after reset release therefore presents (0,0) with ad_out=1.
- Decode, computed from the next position and registered alongside it (latency 0 relative to the counters):
  - hs_out = 1 iff ACTIVE_H+H_FRONT_PORCH <= hcount < ACTIVE_H+H_FRONT_PORCH+H_SYNC_WIDTH (1390..1429).
  - vs_out = 1 iff ACTIVE_LINES+V_FRONT_PORCH <= vcount < ACTIVE_LINES+V_FRONT_PORCH+V_SYNC_WIDTH (725..729), for every pixel of those lines.
  - ad_out = 1 iff hcount < ACTIVE_H and vcount < ACTIVE_LINES.
  - nf_out = 1 iff hcount = ACTIVE_H and vcount = ACTIVE_LINES (1280,720): first blank pixel after the last active line, exactly once per frame.
- Frame counter:
  - fc_out increments in the same cycle nf_out rises.
  - Wraps FPS-1 -> 0.
  - Comparisons and arithmetic are unsigned at the port widths. Constants are sized so H_TOTAL-1 fits 11 bits and V_TOTAL-1 fits 10 bits.
- Reset mid-frame: outputs return to the reset tuple asynchronously. On release, the raster restarts at (0,0) on the first edge. No partial nf_out pulse is emitted.
- No back-pressure and no enable: the raster free-runs.

Decomposition:
- Shared package video_timing_pkg holds:
  - the 720p constants (ACTIVE_H, porches, sync widths, totals);
  - the HCOUNT_W=11 and VCOUNT_W=10 width constants;
  - the TMDS control-token constants, so the encoder and this block share one source.
- No sub-module: two cascaded wrap counters plus comparators are clearer inline.

Test Plan:
- Reset held 5 cycles, then released -> during reset (1649,749), hs=vs=ad=nf=0, fc=0. First edge gives (0,0) with ad=1.
- Run one line from (0,0) -> ad high for exactly 1280 cycles; hs high for exactly 40 cycles starting at hcount=1390; (1649,0) is followed by (0,1).
- Run one full frame -> exactly 1,237,500 cycles between nf pulses:
  - nf high only at (1280,720);
  - vs high for lines 725..729 inclusive (8250 cycles);
  - (1649,749) is followed by (0,0).
- Run 61 frames -> fc steps 0..59, wraps to 0 on the 60th nf pulse, and reads 1 after the 61st.
- Assert rst_n_in asynchronously mid-clock at (640,300) -> outputs jump to the reset tuple before the next edge; after release, restart at (0,0); no nf in between.
- Every cycle of a 2-frame run, the bench checks its reference decode of (hcount_out, vcount_out) against hs/vs/ad/nf -> zero mismatches.
